// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter giving NUM_CORES single-outstanding load/store requesters
// access to one synchronous byte-wide memory, one access in flight at a time.
module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req,
  input  logic [NUM_CORES-1:0]        mem_we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_in,
  output logic [NUM_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]           mem_dat,
  output logic [2:0]                  grant_id,
  output logic                        busy,
  output logic [15:0]                 access_count
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  g_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] dat_hold;
  logic [DATA_W-1:0] resp_dat;
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;

  // Scan last+1, last+2, ... so the most recently served core has lowest priority.
  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_CORES);
      if (!found && mem_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last         <= IDX_W'(NUM_CORES - 1);
      g_q          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_id     <= '0;
      access_count <= '0;
      dat_hold     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g_q      <= pick;
            last     <= pick;
            grant_id <= 3'(pick);
            we_q     <= mem_we[pick];
            addr_q   <= addr_in[pick*ADDR_W +: ADDR_W];
            wdata_q  <= wdata_in[pick*DATA_W +: DATA_W];
            state    <= ACCESS;
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          access_count <= access_count + 16'd1;
          dat_hold     <= resp_dat;
          state        <= RELEASE;
        end
        RELEASE: begin
          // Hold here until the served core drops its request, so it cannot be re-served back to back.
          if (!mem_req[g_q]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array and its read register have no reset; clearing them is not wanted and would defeat RAM mapping.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      if (we_q) mem[addr_q] <= wdata_q;
      else      rd          <= mem[addr_q];
    end
  end

  assign resp_dat = we_q ? wdata_q : rd;
  assign val_data = (state == RESP) ? (NUM_CORES'(1) << g_q) : '0;
  assign mem_dat  = (state == RESP) ? resp_dat : dat_hold;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: a transaction-level timing model checked every
// cycle, plus directed scenarios with literal expectations on order and data.
module tb_shared_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    mem_req;
  logic [N-1:0]    mem_we;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] wdata_in;
  logic [N-1:0]    val_data;
  logic [DW-1:0]   mem_dat;
  logic [2:0]      grant_id;
  logic            busy;
  logic [15:0]     access_count;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .val_data     (val_data),
    .mem_dat      (mem_dat),
    .grant_id     (grant_id),
    .busy         (busy),
    .access_count (access_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the access is resolved at grant time, its response is due two
  // cycles later, and the arbiter is free again once the served core drops its request.
  typedef struct {
    int         cyc;
    int         core;
    logic [7:0] dat;
  } ev_t;

  ev_t        log_q[$];
  bit         started = 1'b0;
  int         cyc = 0;
  bit         m_active;
  int         m_g;
  int         m_last;
  int         m_resp_cyc;
  logic [7:0] m_resp_dat;
  logic [7:0] m_hold;
  logic [15:0] m_cnt;
  logic [2:0] m_grant;
  logic [7:0] mem_m [0:4095];

  task automatic model_reset();
    m_active   = 1'b0;
    m_g        = 0;
    m_last     = N - 1;
    m_resp_cyc = -10;
    m_resp_dat = '0;
    m_hold     = '0;
    m_cnt      = '0;
    m_grant    = '0;
  endtask

  always @(negedge clk) begin
    logic [N-1:0]  exp_val;
    logic [AW-1:0] a;
    ev_t           e;
    if (started) begin
      exp_val = (m_active && cyc == m_resp_cyc) ? (N'(1) << m_g) : '0;
      check("val_data", 32'(val_data), 32'(exp_val));
      check("mem_dat", 32'(mem_dat), 32'((exp_val != 0) ? m_resp_dat : m_hold));
      check("busy", 32'(busy), 32'(m_active));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      check("access_count", 32'(access_count), 32'(m_cnt));
      if (val_data != 0) begin
        e.cyc  = cyc;
        e.core = -1;
        for (int i = 0; i < N; i++) if (val_data[i]) e.core = i;
        e.dat  = mem_dat;
        log_q.push_back(e);
      end
      if (exp_val != 0) begin
        m_cnt  = m_cnt + 16'd1;
        m_hold = m_resp_dat;
      end
      if (reset) begin
        model_reset();
      end else if (m_active) begin
        if (cyc > m_resp_cyc && !mem_req[m_g]) m_active = 1'b0;
      end else if (mem_req != 0) begin
        for (int i = 1; i <= N; i++) begin
          if (mem_req[(m_last + i) % N]) begin
            m_g = (m_last + i) % N;
            break;
          end
        end
        m_last     = m_g;
        m_grant    = 3'(m_g);
        m_active   = 1'b1;
        m_resp_cyc = cyc + 2;
        a          = addr_in[m_g*AW +: AW];
        if (mem_we[m_g]) begin
          mem_m[a]   = wdata_in[m_g*DW +: DW];
          m_resp_dat = wdata_in[m_g*DW +: DW];
        end else begin
          m_resp_dat = mem_m[a];
        end
      end
    end
    cyc++;
  end

  // Core behaviour: drop the request the cycle after val_data, or hold_left cycles later.
  bit [N-1:0] dropping = '0;
  int         hold_left [N];

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < N; k++) if (val_data[k]) dropping[k] = 1'b1;
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      if (dropping[k]) begin
        if (hold_left[k] == 0) begin
          mem_req[k]  = 1'b0;
          dropping[k] = 1'b0;
        end else begin
          hold_left[k]--;
        end
      end
    end
  endtask

  task automatic request(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_we[k]              = we;
    addr_in[k*AW +: AW]    = a;
    wdata_in[k*DW +: DW]   = d;
    mem_req[k]             = 1'b1;
  endtask

  task automatic wait_events(input string name, input int n, input int budget);
    for (int i = 0; i < budget && log_q.size() < n; i++) tick();
    check(name, 32'(log_q.size() >= n), 32'd1);
  endtask

  function automatic int ev_core(input int i);
    return (i < log_q.size()) ? log_q[i].core : -1;
  endfunction

  function automatic logic [7:0] ev_dat(input int i);
    return (i < log_q.size()) ? log_q[i].dat : 8'hxx;
  endfunction

  function automatic int ev_cyc(input int i);
    return (i < log_q.size()) ? log_q[i].cyc : -1000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int k = 0; k < N; k++) hold_left[k] = 0;
    reset    = 1'b1;
    mem_req  = '0;
    mem_we   = '0;
    addr_in  = '0;
    wdata_in = '0;
    model_reset();
    repeat (2) tick();
    reset   = 1'b0;
    started = 1'b1;
    tick();

    check("rst_val_data", 32'(val_data), 32'd0);
    check("rst_mem_dat", 32'(mem_dat), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_access_count", 32'(access_count), 32'd0);

    // Core 1 store then load of the same address.
    log_q.delete();
    request(1, 1'b1, 12'h3C7, 8'h5A);
    t0 = cyc;
    wait_events("t1_store_seen", 1, 20);
    check("t1_store_core", 32'(ev_core(0)), 32'd1);
    check("t1_store_latency", 32'(ev_cyc(0) - t0), 32'd2);
    tick();
    request(1, 1'b0, 12'h3C7, 8'h00);
    wait_events("t1_load_seen", 2, 20);
    check("t1_load_core", 32'(ev_core(1)), 32'd1);
    check("t1_load_data", 32'(ev_dat(1)), 32'h5A);
    check("t1_count", 32'(access_count), 32'd2);

    // After reset, all four cores load together.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    log_q.delete();
    for (int k = 0; k < N; k++) request(k, 1'b0, 12'h3C7, 8'h00);
    wait_events("t2_seen", 4, 40);
    for (int k = 0; k < N; k++) begin
      check($sformatf("t2_order_%0d", k), 32'(ev_core(k)), 32'(k));
      check($sformatf("t2_data_%0d", k), 32'(ev_dat(k)), 32'h5A);
    end
    for (int k = 1; k < N; k++)
      check($sformatf("t2_spacing_%0d", k), 32'(ev_cyc(k) - ev_cyc(k - 1)), 32'd4);
    check("t2_count", 32'(access_count), 32'd4);

    // Make core 2 the last served, then cores 0 and 3 collide: 3 wins.
    tick();
    log_q.delete();
    request(2, 1'b1, 12'h010, 8'h11);
    wait_events("t3_prime_seen", 1, 20);
    tick();
    log_q.delete();
    request(0, 1'b0, 12'h010, 8'h00);
    request(3, 1'b1, 12'h020, 8'h22);
    wait_events("t3_seen", 2, 30);
    check("t3_first", 32'(ev_core(0)), 32'd3);
    check("t3_second", 32'(ev_core(1)), 32'd0);
    check("t3_load_data", 32'(ev_dat(1)), 32'h11);

    // Core 2 keeps its request high for 5 cycles after completion.
    tick();
    log_q.delete();
    hold_left[2] = 5;
    request(2, 1'b0, 12'h020, 8'h00);
    wait_events("t4_seen", 1, 20);
    check("t4_data", 32'(ev_dat(0)), 32'h22);
    repeat (4) tick();
    check("t4_busy_held", 32'(busy), 32'd1);
    check("t4_no_repeat", 32'(log_q.size()), 32'd1);
    repeat (3) tick();
    check("t4_busy_released", 32'(busy), 32'd0);
    check("t4_still_one", 32'(log_q.size()), 32'd1);

    // Reset during ACCESS of a load abandons it.
    tick();
    log_q.delete();
    request(1, 1'b0, 12'h3C7, 8'h00);
    tick();
    reset      = 1'b1;
    mem_req[1] = 1'b0;
    tick();
    check("t5_val_data", 32'(val_data), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_count", 32'(access_count), 32'd0);
    check("t5_grant_id", 32'(grant_id), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("t5_no_response", 32'(log_q.size()), 32'd0);
    request(3, 1'b1, 12'h123, 8'h77);
    wait_events("t5_fresh_seen", 1, 20);
    check("t5_fresh_core", 32'(ev_core(0)), 32'd3);
    check("t5_fresh_data", 32'(ev_dat(0)), 32'h77);
    check("t5_fresh_count", 32'(access_count), 32'd1);

    // Store and load of the top address requested together.
    tick();
    log_q.delete();
    request(0, 1'b1, 12'hFFF, 8'hFF);
    request(1, 1'b0, 12'hFFF, 8'h00);
    wait_events("t6_seen", 2, 30);
    check("t6_first", 32'(ev_core(0)), 32'd0);
    check("t6_second", 32'(ev_core(1)), 32'd1);
    check("t6_load_data", 32'(ev_dat(1)), 32'hFF);
    check("t6_count", 32'(access_count), 32'd3);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
